// File: rtl/instruction_fetch_sequencer.sv
// Program sequencer: owns the PC, drives the ROM address and registers fetched words into a valid/ready slot.
// Optional performance counters are enabled with `define FETCH_PERF_COUNT_EN.
module instruction_fetch_sequencer #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned INSTR_W = 28,
  parameter logic [3:0]  NOP_OP  = 4'hE,
  parameter logic [3:0]  JMP_OP  = 4'hF
) (
  input  logic               Clock,
  input  logic               Reset,
  output logic [ADDR_W-1:0]  oAddress,
  input  logic [INSTR_W-1:0] iInstruction,
  output logic [INSTR_W-1:0] oInstruction,
  output logic               oValid,
  input  logic               iReady,
  input  logic               iRedirect,
  input  logic [ADDR_W-1:0]  iRedirectTarget,
  input  logic               iHalt,
  output logic               oDelayActive
`ifdef FETCH_PERF_COUNT_EN
  ,
  output logic [15:0]        oIssueCount,
  output logic [15:0]        oStallCount
`endif
);

  typedef enum logic {S_FETCH, S_DELAY} state_t;

  state_t      state;
  logic [23:0] cnt;
  logic        slot_free;
  logic        transfer;
  logic [3:0]  opcode;
  logic [23:0] nop_count;

  assign slot_free    = !oValid || iReady;
  assign transfer     = oValid && iReady;
  // Opcode occupies the top nibble; a NOP's count and a JMP's target overlap the fields below it.
  assign opcode       = iInstruction[27:24];
  assign nop_count    = iInstruction[23:0];
  assign oDelayActive = (state == S_DELAY);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state        <= S_FETCH;
      oAddress     <= '0;
      oInstruction <= '0;
      oValid       <= 1'b0;
      cnt          <= '0;
    end else if (iRedirect) begin
      state    <= S_FETCH;
      oAddress <= iRedirectTarget;
      oValid   <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (!iHalt && slot_free) begin
            oInstruction <= iInstruction;
            oValid       <= 1'b1;
            if (opcode == JMP_OP) begin
              oAddress <= ADDR_W'(iInstruction[23:16]);
            end else begin
              oAddress <= oAddress + ADDR_W'(1);
              if (opcode == NOP_OP && nop_count != '0) begin
                cnt   <= nop_count;
                state <= S_DELAY;
              end
            end
          end else if (transfer) begin
            oValid <= 1'b0;
          end
        end
        S_DELAY: begin
          if (transfer) oValid <= 1'b0;
          if (!iHalt) begin
            cnt <= cnt - 24'd1;
            if (cnt <= 24'd1) state <= S_FETCH;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

`ifdef FETCH_PERF_COUNT_EN
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      oIssueCount <= '0;
      oStallCount <= '0;
    end else begin
      if (transfer && oIssueCount != '1) oIssueCount <= oIssueCount + 16'd1;
      if (oValid && !iReady && oStallCount != '1) oStallCount <= oStallCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Directed self-checking bench for instruction_fetch_sequencer with a modelled combinational ROM.
module tb_instruction_fetch_sequencer;

  localparam logic [3:0] NOP = 4'hE;
  localparam logic [3:0] JMP = 4'hF;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] oAddress;
  logic [27:0] iInstruction;
  logic [27:0] oInstruction;
  logic        oValid;
  logic        iReady;
  logic        iRedirect;
  logic [15:0] iRedirectTarget;
  logic        iHalt;
  logic        oDelayActive;
`ifdef FETCH_PERF_COUNT_EN
  logic [15:0] oIssueCount;
  logic [15:0] oStallCount;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 Clock = ~Clock;

  function automatic logic [27:0] rom(input logic [15:0] a);
    case (a)
      16'd0:   rom = {NOP, 24'd4000};
      16'd18:  rom = {JMP, 8'd4, 16'd0};
      16'd30:  rom = {NOP, 24'd5};
      default: rom = {4'h1, 8'h00, a};
    endcase
  endfunction

  assign iInstruction = rom(oAddress);

  instruction_fetch_sequencer #(
    .ADDR_W (16),
    .INSTR_W(28),
    .NOP_OP (NOP),
    .JMP_OP (JMP)
  ) dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .oAddress       (oAddress),
    .iInstruction   (iInstruction),
    .oInstruction   (oInstruction),
    .oValid         (oValid),
    .iReady         (iReady),
    .iRedirect      (iRedirect),
    .iRedirectTarget(iRedirectTarget),
    .iHalt          (iHalt),
    .oDelayActive   (oDelayActive)
`ifdef FETCH_PERF_COUNT_EN
    ,
    .oIssueCount    (oIssueCount),
    .oStallCount    (oStallCount)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic redirect(input logic [15:0] t);
    iRedirect       = 1'b1;
    iRedirectTarget = t;
    step();
    iRedirect = 1'b0;
  endtask

  initial begin
    int unsigned n;
    logic [27:0] held_i;
    logic [15:0] held_a;
`ifdef FETCH_PERF_COUNT_EN
    logic [15:0] stall0;
`endif
    Reset = 1'b0; iReady = 1'b1; iRedirect = 1'b0; iRedirectTarget = '0; iHalt = 1'b0;
    #3;
    check("rst_valid", 32'(oValid), 32'd0);
    check("rst_addr", 32'(oAddress), 32'd0);
    check("rst_delay", 32'(oDelayActive), 32'd0);
    check("rst_instr", 32'(oInstruction), 32'd0);
    #9 Reset = 1'b1;

    // 4000-cycle NOP at address 0
    step();
    check("nop_issue", 32'(oInstruction), 32'(rom(16'd0)));
    check("nop_valid", 32'(oValid), 32'd1);
    check("nop_addr", 32'(oAddress), 32'd1);
    n = 0;
    while (oDelayActive && n < 5000) begin
      step();
      n++;
    end
    check("nop_len", n, 32'd4000);
    check("nop_drained", 32'(oValid), 32'd0);
    check("nop_addr_hold", 32'(oAddress), 32'd1);
    step();
    check("after_nop", 32'(oInstruction), 32'(rom(16'd1)));
    check("after_nop_v", 32'(oValid), 32'd1);

    // JMP at 18 -> 4
    redirect(16'd17);
    check("rd17_valid", 32'(oValid), 32'd0);
    check("rd17_addr", 32'(oAddress), 32'd17);
    step();
    check("i17", 32'(oInstruction), 32'(rom(16'd17)));
    check("a18", 32'(oAddress), 32'd18);
    step();
    check("jmp_instr", 32'(oInstruction), 32'(rom(16'd18)));
    check("jmp_addr", 32'(oAddress), 32'd4);
    step();
    check("i4", 32'(oInstruction), 32'(rom(16'd4)));
    check("a5", 32'(oAddress), 32'd5);

    // 3-cycle stall
    held_i = oInstruction;
    held_a = oAddress;
`ifdef FETCH_PERF_COUNT_EN
    stall0 = oStallCount;
`endif
    iReady = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("stall_instr", 32'(oInstruction), 32'(held_i));
    check("stall_addr", 32'(oAddress), 32'(held_a));
    check("stall_valid", 32'(oValid), 32'd1);
`ifdef FETCH_PERF_COUNT_EN
    check("stall_cnt", 32'(oStallCount), 32'(stall0) + 32'd3);
`endif
    iReady = 1'b1;
    step();
    check("unstall_instr", 32'(oInstruction), 32'(rom(held_a)));
    check("unstall_addr", 32'(oAddress), 32'(held_a) + 32'd1);

    // redirect while slot full and being consumed
    redirect(16'd11);
    check("rd11_valid", 32'(oValid), 32'd0);
    check("rd11_addr", 32'(oAddress), 32'd11);
    step();
    check("rd11_instr", 32'(oInstruction), 32'(rom(16'd11)));
    check("rd11_v", 32'(oValid), 32'd1);

    // PC wrap
    redirect(16'hFFFF);
    step();
    check("wrap_instr", 32'(oInstruction), 32'(rom(16'hFFFF)));
    check("wrap_addr", 32'(oAddress), 32'd0);

    // halt freezes delay counter (5-cycle NOP at 30)
    redirect(16'd30);
    step();
    check("n5_delay", 32'(oDelayActive), 32'd1);
    iHalt = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("halt_delay", 32'(oDelayActive), 32'd1);
    iHalt = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("halt_delay4", 32'(oDelayActive), 32'd1);
    step();
    check("halt_delay_end", 32'(oDelayActive), 32'd0);
    step();
    check("halt_next", 32'(oInstruction), 32'(rom(16'd31)));

    // async reset mid-DELAY with slot held full
    redirect(16'd0);
    iReady = 1'b0;
    step();
    for (int i = 0; i < 2000; i++) step();
    check("pre_rst_valid", 32'(oValid), 32'd1);
    check("pre_rst_delay", 32'(oDelayActive), 32'd1);
    #2 Reset = 1'b0;
    #1;
    check("mid_rst_valid", 32'(oValid), 32'd0);
    check("mid_rst_addr", 32'(oAddress), 32'd0);
    check("mid_rst_delay", 32'(oDelayActive), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
